spif_arbiter: RTL and testbench
===============================

# spif_arbiter

Shares the MCU's single SPI flash byte engine between two requesters: the UART in-system-programming (ISP) path and the CPU flash-access port. A requester owns the flash for a whole chip-select transaction, from its first byte until it issues a raise-CS command. The arbiter routes read data back to the owner and forces a raise-CS if the owner stalls past a watchdog limit. It sits between the ISP/CPU front ends and the SPI byte engine that drives sclk/cs_n/qdo/oe.

## Interface
- TIMEOUT, 4096: idle cycles an owner may hold CS before a forced release; must be ≥2.
- TW, $clog2(TIMEOUT): watchdog counter width.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- isp_req_valid / cpu_req_valid  in  1  command offered
- isp_req_ready / cpu_req_ready  out  1  command accepted this cycle
- isp_req_cmd / cpu_req_cmd  in  2  00 write byte, 01 read byte, 10/11 raise cs_n (no byte)
- isp_req_data / cpu_req_data  in  8  write byte
- isp_req_quad / cpu_req_quad  in  1  1 = quad lanes, 0 = single
- isp_rsp_valid / cpu_rsp_valid  out  1  read byte returned
- isp_rsp_data / cpu_rsp_data  out  8  read byte
- isp_lock  in  1  ISP session active; blocks new CPU grants
- eng_valid  out  1  command to engine
- eng_ready  in  1  engine accepts
- eng_cmd  out  2  same encoding as req_cmd
- eng_data  out  8  write byte
- eng_quad  out  1  lane mode
- eng_rsp_valid  in  1  engine read byte ready
- eng_rsp_data  in  8  engine read byte
- owner  out  2  0 none, 1 ISP, 2 CPU
- timeout_evt  out  1  one-cycle pulse on forced release

## Operation
- States: IDLE, OWN_ISP, OWN_CPU, FLUSH.
- IDLE: no request is accepted.
  - isp_req_valid alone → OWN_ISP.
  - cpu_req_valid alone with isp_lock=0 → OWN_CPU.
  - Both valid with isp_lock=0 → requester not equal to last_owner wins (round-robin); last_owner resets to CPU, so ISP wins the first tie.
  - isp_lock=1 → CPU never granted, even if already waiting.
- OWN_x: eng_valid/cmd/data/quad = owner's request signals.
  - owner req_ready = eng_ready & ~rd_pend.
  - Non-owner req_ready = 0.
- Accepted read (cmd 01) sets rd_pend. eng_rsp_valid clears it and is forwarded to the owner's rsp port.
- Accepted raise-CS → release pending.
  - Return to IDLE once rd_pend = 0; same cycle if already 0.
  - last_owner updates at release.
- isp_lock rising while OWN_CPU: no preemption; CPU finishes its transaction.
- Watchdog counter:
  - Cleared on grant and on every accepted owner command.
  - Increments in OWN_x while owner req_valid=0 and rd_pend=0.
  - At TIMEOUT-1 → FLUSH.
- FLUSH: eng_valid=1, eng_cmd=10, both req_ready=0. On eng_ready → IDLE, timeout_evt=1 for one cycle, last_owner updated.
- eng_rsp_valid with rd_pend=0: ignored (no rsp pulse).

## Timing
- Reset values: state IDLE, owner 0, rd_pend 0, watchdog 0, last_owner CPU; all ready/valid/rsp outputs 0; eng_* data 0; timeout_evt 0.
- Reset mid-transaction: everything returns to reset values next cycle. The engine shares rst and raises cs_n itself.
- Grant latency: request seen in IDLE at cycle N; owner registered at N+1; first command can be accepted at N+1.
- Engine command path is combinational from owner to engine (no added latency).
- Response path is registered: rsp_valid/rsp_data appear one cycle after eng_rsp_valid.
- Only one read outstanding; the owner is stalled until its response returns.
- Release to next grant: IDLE for at least one cycle between owners.

## Structure
- Package spif_pkg holds:
  - cmd encodings CMD_WR=2'b00, CMD_RD=2'b01, CMD_END=2'b10;
  - owner codes OWN_NONE/ISP/CPU;
  - state enum.
- Sub-module spif_wdog (TW-bit counter with clear/enable inputs and expire output) keeps the FSM file small.

## Test plan
- ISP alone: write 9F, three reads, raise-CS. Engine returns EF,40,17; isp_rsp carries EF,40,17 each one cycle later; owner 1→0 after release; CPU rsp stays 0.
- Simultaneous ISP and CPU requests from reset, isp_lock=0: ISP wins. After the ISP raise-CS, the second tie goes to CPU.
- isp_lock=1 with CPU requesting from IDLE: owner stays 0 for 100 cycles. Dropping the lock grants CPU on the next cycle.
- CPU writes 03 then stalls for TIMEOUT cycles (TIMEOUT=16): FLUSH issues eng_cmd=10; timeout_evt pulses once; owner→0.
- Read outstanding with owner raise-CS valid: raise-CS is not accepted until the response returns; release follows. An unsolicited eng_rsp_valid in IDLE produces no rsp pulse.
- rst asserted mid-read: next cycle owner=0, eng_valid=0, no rsp pulse after reset deasserts.

Source files
------------

// File: rtl/spif_pkg.sv
// Shared encodings for the SPI flash arbiter: command codes, owner codes
// and the arbitration state enum.
package spif_pkg;

  localparam logic [1:0] CMD_WR  = 2'b00;
  localparam logic [1:0] CMD_RD  = 2'b01;
  localparam logic [1:0] CMD_END = 2'b10;

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_ISP  = 2'd1;
  localparam logic [1:0] OWN_CPU  = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_OWN_ISP = 2'd1,
    ST_OWN_CPU = 2'd2,
    ST_FLUSH   = 2'd3
  } state_t;

  // Both 10 and 11 raise cs_n, so only the upper bit matters.
  function automatic logic is_end(input logic [1:0] cmd);
    return cmd[1];
  endfunction

endpackage

// File: rtl/spif_arbiter_if.sv
// Bundle of requester, engine and status signals around the arbiter.
// slave = arbiter view, master = surrounding front ends and byte engine.
interface spif_arbiter_if;

  logic       isp_req_valid;
  logic       isp_req_ready;
  logic [1:0] isp_req_cmd;
  logic [7:0] isp_req_data;
  logic       isp_req_quad;
  logic       isp_rsp_valid;
  logic [7:0] isp_rsp_data;

  logic       cpu_req_valid;
  logic       cpu_req_ready;
  logic [1:0] cpu_req_cmd;
  logic [7:0] cpu_req_data;
  logic       cpu_req_quad;
  logic       cpu_rsp_valid;
  logic [7:0] cpu_rsp_data;

  logic       isp_lock;

  logic       eng_valid;
  logic       eng_ready;
  logic [1:0] eng_cmd;
  logic [7:0] eng_data;
  logic       eng_quad;
  logic       eng_rsp_valid;
  logic [7:0] eng_rsp_data;

  logic [1:0] owner;
  logic       timeout_evt;

  modport slave (
    input  isp_req_valid, isp_req_cmd, isp_req_data, isp_req_quad,
    input  cpu_req_valid, cpu_req_cmd, cpu_req_data, cpu_req_quad,
    input  isp_lock, eng_ready, eng_rsp_valid, eng_rsp_data,
    output isp_req_ready, isp_rsp_valid, isp_rsp_data,
    output cpu_req_ready, cpu_rsp_valid, cpu_rsp_data,
    output eng_valid, eng_cmd, eng_data, eng_quad,
    output owner, timeout_evt
  );

  modport master (
    output isp_req_valid, isp_req_cmd, isp_req_data, isp_req_quad,
    output cpu_req_valid, cpu_req_cmd, cpu_req_data, cpu_req_quad,
    output isp_lock, eng_ready, eng_rsp_valid, eng_rsp_data,
    input  isp_req_ready, isp_rsp_valid, isp_rsp_data,
    input  cpu_req_ready, cpu_rsp_valid, cpu_rsp_data,
    input  eng_valid, eng_cmd, eng_data, eng_quad,
    input  owner, timeout_evt
  );

endinterface

// File: rtl/spif_wdog.sv
// Owner-stall watchdog: counts idle owner cycles and flags expiry at
// TIMEOUT-1. The count parks at expiry until the next clear.
module spif_wdog #(
  parameter int TIMEOUT = 4096,
  parameter int TW      = $clog2(TIMEOUT)
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expire
);

  logic [TW-1:0] r_cnt;

  assign o_expire = (r_cnt == TW'(TIMEOUT - 1));

  // Idle-cycle counter; clear wins over enable
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && !o_expire) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/spif_arbiter.sv
// Arbitrates the single SPI flash byte engine between the ISP and CPU
// requesters. Ownership spans a whole chip-select transaction; a stalled
// owner is cut off by a forced raise-CS after TIMEOUT idle cycles.
module spif_arbiter
  import spif_pkg::*;
#(
  parameter int TIMEOUT = 4096,
  parameter int TW      = $clog2(TIMEOUT)
) (
  input  logic           clk,
  input  logic           rst,
  spif_arbiter_if.slave  bus
);

  state_t     r_state;
  state_t     w_state_nxt;
  logic [1:0] r_owner;
  logic [1:0] r_last_owner;
  logic       r_rd_pend;
  logic       r_timeout_evt;
  logic       r_isp_rsp_valid;
  logic [7:0] r_isp_rsp_data;
  logic       r_cpu_rsp_valid;
  logic [7:0] r_cpu_rsp_data;

  logic       w_own_valid;
  logic [1:0] w_own_cmd;
  logic [7:0] w_own_data;
  logic       w_own_quad;
  logic       w_own_state;
  logic       w_accept;
  logic       w_cpu_elig;
  logic       w_rsp_take;
  logic       w_grant_isp;
  logic       w_grant_cpu;
  logic       w_release;
  logic       w_flush_done;
  logic       w_wd_expire;

  assign w_own_state = (r_state == ST_OWN_ISP) || (r_state == ST_OWN_CPU);

  // Select the current owner's request onto common wires
  always_comb begin
    w_own_valid = 1'b0;
    w_own_cmd   = CMD_WR;
    w_own_data  = 8'h00;
    w_own_quad  = 1'b0;
    case (r_state)
      ST_OWN_ISP: begin
        w_own_valid = bus.isp_req_valid;
        w_own_cmd   = bus.isp_req_cmd;
        w_own_data  = bus.isp_req_data;
        w_own_quad  = bus.isp_req_quad;
      end
      ST_OWN_CPU: begin
        w_own_valid = bus.cpu_req_valid;
        w_own_cmd   = bus.cpu_req_cmd;
        w_own_data  = bus.cpu_req_data;
        w_own_quad  = bus.cpu_req_quad;
      end
      default: ;
    endcase
  end

  // A read in flight stalls the owner, so nothing new reaches the engine.
  assign w_accept   = w_own_state & w_own_valid & bus.eng_ready & ~r_rd_pend;
  assign w_cpu_elig = bus.cpu_req_valid & ~bus.isp_lock;
  assign w_rsp_take = bus.eng_rsp_valid & r_rd_pend;

  // Next-state and grant/release decisions
  always_comb begin
    w_state_nxt  = r_state;
    w_grant_isp  = 1'b0;
    w_grant_cpu  = 1'b0;
    w_release    = 1'b0;
    w_flush_done = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.isp_req_valid && w_cpu_elig) begin
          w_grant_isp = (r_last_owner == OWN_CPU);
          w_grant_cpu = (r_last_owner != OWN_CPU);
        end else begin
          w_grant_isp = bus.isp_req_valid;
          w_grant_cpu = w_cpu_elig;
        end
        if (w_grant_isp) begin
          w_state_nxt = ST_OWN_ISP;
        end else if (w_grant_cpu) begin
          w_state_nxt = ST_OWN_CPU;
        end
      end
      ST_OWN_ISP, ST_OWN_CPU: begin
        // Raise-CS is only accepted with no read pending, so release is immediate.
        if (w_accept && is_end(w_own_cmd)) begin
          w_state_nxt = ST_IDLE;
          w_release   = 1'b1;
        end else if (w_wd_expire && !w_accept) begin
          w_state_nxt = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        if (bus.eng_ready) begin
          w_state_nxt  = ST_IDLE;
          w_release    = 1'b1;
          w_flush_done = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  spif_wdog #(
    .TIMEOUT (TIMEOUT),
    .TW      (TW)
  ) u_wdog (
    .clk      (clk),
    .rst      (rst),
    .i_clr    (w_grant_isp | w_grant_cpu | w_accept),
    .i_en     (w_own_state & ~w_own_valid & ~r_rd_pend),
    .o_expire (w_wd_expire)
  );

  // State, ownership, read tracking and timeout pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_owner       <= OWN_NONE;
      r_last_owner  <= OWN_CPU;
      r_rd_pend     <= 1'b0;
      r_timeout_evt <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_timeout_evt <= w_flush_done;
      if (w_grant_isp) begin
        r_owner <= OWN_ISP;
      end else if (w_grant_cpu) begin
        r_owner <= OWN_CPU;
      end else if (w_release) begin
        r_owner <= OWN_NONE;
      end
      if (w_release) begin
        r_last_owner <= r_owner;
      end
      if (w_accept && (w_own_cmd == CMD_RD)) begin
        r_rd_pend <= 1'b1;
      end else if (w_rsp_take) begin
        r_rd_pend <= 1'b0;
      end
    end
  end

  // Register engine read data toward whichever requester owns the read
  always_ff @(posedge clk) begin
    if (rst) begin
      r_isp_rsp_valid <= 1'b0;
      r_isp_rsp_data  <= 8'h00;
      r_cpu_rsp_valid <= 1'b0;
      r_cpu_rsp_data  <= 8'h00;
    end else begin
      r_isp_rsp_valid <= w_rsp_take && (r_owner == OWN_ISP);
      r_cpu_rsp_valid <= w_rsp_take && (r_owner == OWN_CPU);
      if (w_rsp_take && (r_owner == OWN_ISP)) begin
        r_isp_rsp_data <= bus.eng_rsp_data;
      end
      if (w_rsp_take && (r_owner == OWN_CPU)) begin
        r_cpu_rsp_data <= bus.eng_rsp_data;
      end
    end
  end

  assign bus.isp_req_ready = (r_state == ST_OWN_ISP) & bus.eng_ready & ~r_rd_pend;
  assign bus.cpu_req_ready = (r_state == ST_OWN_CPU) & bus.eng_ready & ~r_rd_pend;

  assign bus.eng_valid = (r_state == ST_FLUSH) | (w_own_state & w_own_valid & ~r_rd_pend);
  assign bus.eng_cmd   = (r_state == ST_FLUSH) ? CMD_END : w_own_cmd;
  assign bus.eng_data  = w_own_data;
  assign bus.eng_quad  = w_own_quad;

  assign bus.isp_rsp_valid = r_isp_rsp_valid;
  assign bus.isp_rsp_data  = r_isp_rsp_data;
  assign bus.cpu_rsp_valid = r_cpu_rsp_valid;
  assign bus.cpu_rsp_data  = r_cpu_rsp_data;
  assign bus.owner         = r_owner;
  assign bus.timeout_evt   = r_timeout_evt;

endmodule

// File: tb/tb_spif_arbiter.sv
// Directed bench for spif_arbiter with a small byte-engine model and a
// response scoreboard (expected read bytes queued per requester).
module tb_spif_arbiter;
  import spif_pkg::*;

  logic clk;
  logic rst;

  spif_arbiter_if bus ();

  spif_arbiter #(.TIMEOUT(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_isp_q[$];
  logic [7:0] exp_cpu_q[$];
  logic [7:0] eng_q[$];

  int         rd_delay = 0;
  bit         unsol_pend = 0;
  logic [1:0] last_eng_cmd = 2'b11;
  logic [7:0] last_wr = 8'h00;
  logic       last_quad = 1'b0;
  logic       eng_rsp_prev = 1'b0;
  int         n_isp_rsp = 0;
  int         n_cpu_rsp = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Offer one command from a requester; returns one tick after acceptance.
  task automatic send(input bit isp, input logic [1:0] cmd, input logic [7:0] d,
                      input logic quad, input string tag);
    bit ok;
    ok = 0;
    if (isp) begin
      bus.isp_req_valid = 1; bus.isp_req_cmd = cmd; bus.isp_req_data = d; bus.isp_req_quad = quad;
    end else begin
      bus.cpu_req_valid = 1; bus.cpu_req_cmd = cmd; bus.cpu_req_data = d; bus.cpu_req_quad = quad;
    end
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (isp ? bus.isp_req_ready : bus.cpu_req_ready) begin
        ok = 1;
        break;
      end
    end
    @(posedge clk); #1;
    if (isp) bus.isp_req_valid = 0; else bus.cpu_req_valid = 0;
    check({tag, " accepted"}, 32'(ok), 1);
  endtask

  task automatic send_rd(input bit isp, input logic [7:0] b, input string tag);
    if (isp) exp_isp_q.push_back(b); else exp_cpu_q.push_back(b);
    eng_q.push_back(b);
    send(isp, CMD_RD, 8'h00, 1'b1, tag);
  endtask

  task automatic do_reset();
    rst = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;
  endtask

  initial begin
    int bad;
    int stall;
    int flush_i;
    int own0_i;
    int evt_n;
    int flush_rdy;
    int seen;
    int pre_isp;
    int pre_cpu;

    clk = 0; rst = 1;
    bus.isp_req_valid = 0; bus.isp_req_cmd = 0; bus.isp_req_data = 0; bus.isp_req_quad = 0;
    bus.cpu_req_valid = 0; bus.cpu_req_cmd = 0; bus.cpu_req_data = 0; bus.cpu_req_quad = 0;
    bus.isp_lock = 0; bus.eng_ready = 1; bus.eng_rsp_valid = 0; bus.eng_rsp_data = 0;

    fork
      // Byte engine: always ready, returns each read byte three cycles later
      forever begin
        @(negedge clk);
        if (rd_delay > 0) begin
          rd_delay--;
          if (rd_delay == 0) begin
            bus.eng_rsp_valid = 1;
            bus.eng_rsp_data  = (eng_q.size() > 0) ? eng_q.pop_front() : 8'h00;
          end
        end else if (unsol_pend) begin
          bus.eng_rsp_valid = 1;
          bus.eng_rsp_data  = 8'h5A;
          unsol_pend = 0;
        end else begin
          bus.eng_rsp_valid = 0;
        end
        if (bus.eng_valid && bus.eng_ready) begin
          last_eng_cmd = bus.eng_cmd;
          last_quad    = bus.eng_quad;
          if (bus.eng_cmd == CMD_WR) last_wr = bus.eng_data;
          if (bus.eng_cmd == CMD_RD) rd_delay = 3;
        end
      end
      forever begin
        @(posedge clk);
        eng_rsp_prev = bus.eng_rsp_valid;
      end
      // Response scoreboard
      forever begin
        @(negedge clk);
        if (bus.isp_rsp_valid) begin
          n_isp_rsp++;
          check("isp rsp expected", 32'(exp_isp_q.size() > 0), 1);
          check("isp rsp latency", 32'(eng_rsp_prev), 1);
          if (exp_isp_q.size() > 0) check("isp rsp data", 32'(bus.isp_rsp_data), 32'(exp_isp_q.pop_front()));
        end
        if (bus.cpu_rsp_valid) begin
          n_cpu_rsp++;
          check("cpu rsp expected", 32'(exp_cpu_q.size() > 0), 1);
          check("cpu rsp latency", 32'(eng_rsp_prev), 1);
          if (exp_cpu_q.size() > 0) check("cpu rsp data", 32'(bus.cpu_rsp_data), 32'(exp_cpu_q.pop_front()));
        end
      end
      begin
        #100000;
        $display("FAIL global timeout: checks %0d errors %0d", checks, errors);
        $fatal(1, "bench timeout");
      end
    join_none

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst owner", 32'(bus.owner), 0);
    check("rst eng_valid", 32'(bus.eng_valid), 0);
    check("rst eng_data", 32'(bus.eng_data), 0);
    check("rst isp_ready", 32'(bus.isp_req_ready), 0);
    check("rst cpu_ready", 32'(bus.cpu_req_ready), 0);
    check("rst isp_rsp", 32'(bus.isp_rsp_valid), 0);
    check("rst cpu_rsp", 32'(bus.cpu_rsp_valid), 0);
    check("rst timeout_evt", 32'(bus.timeout_evt), 0);
    @(posedge clk); #1 rst = 0;

    // ISP alone: write 9F, three reads, raise-CS
    send(1, CMD_WR, 8'h9F, 1'b0, "isp wr 9f");
    check("isp owner", 32'(bus.owner), 1);
    check("eng wr data", 32'(last_wr), 32'h9F);
    send_rd(1, 8'hEF, "isp rd1");
    check("eng quad", 32'(last_quad), 1);
    send_rd(1, 8'h40, "isp rd2");
    send_rd(1, 8'h17, "isp rd3");
    send(1, CMD_END, 8'h00, 1'b0, "isp end");
    @(negedge clk);
    check("isp release owner", 32'(bus.owner), 0);
    check("isp rsp count", 32'(n_isp_rsp), 3);
    check("cpu rsp count", 32'(n_cpu_rsp), 0);
    check("cpu rsp data idle", 32'(bus.cpu_rsp_data), 0);
    check("eng last cmd end", 32'(last_eng_cmd), 32'(CMD_END));

    // Round-robin ties from reset
    do_reset();
    bus.isp_req_valid = 1; bus.isp_req_cmd = CMD_WR; bus.isp_req_data = 8'h11;
    bus.cpu_req_valid = 1; bus.cpu_req_cmd = CMD_WR; bus.cpu_req_data = 8'h22;
    @(negedge clk);
    check("tie idle owner", 32'(bus.owner), 0);
    @(negedge clk);
    check("tie1 winner", 32'(bus.owner), 1);
    check("tie1 cpu ready", 32'(bus.cpu_req_ready), 0);
    @(posedge clk); #1;
    bus.isp_req_cmd = CMD_END;
    @(posedge clk); #1;
    bus.isp_req_cmd = CMD_WR; bus.isp_req_data = 8'h33;
    @(negedge clk);
    check("release gap owner", 32'(bus.owner), 0);
    @(negedge clk);
    check("tie2 winner", 32'(bus.owner), 2);
    check("tie2 isp ready", 32'(bus.isp_req_ready), 0);
    @(posedge clk); #1;
    bus.cpu_req_cmd = CMD_END;
    @(posedge clk); #1;
    bus.cpu_req_valid = 0;
    check("cpu wr 22", 32'(last_wr), 32'h22);
    send(1, CMD_END, 8'h00, 1'b0, "isp end after tie");
    @(negedge clk);
    check("tie done owner", 32'(bus.owner), 0);

    // isp_lock blocks a waiting CPU
    @(posedge clk); #1;
    bus.isp_lock = 1;
    bus.cpu_req_valid = 1; bus.cpu_req_cmd = CMD_WR; bus.cpu_req_data = 8'h44;
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (bus.owner != 0 || bus.cpu_req_ready) bad++;
    end
    check("lock hold cycles", 32'(bad), 0);
    @(posedge clk); #1 bus.isp_lock = 0;
    @(negedge clk);
    check("lock drop idle", 32'(bus.owner), 0);
    @(negedge clk);
    check("lock drop grant", 32'(bus.owner), 2);
    @(posedge clk); #1;
    bus.isp_lock = 1;
    bus.cpu_req_cmd = CMD_END;
    @(negedge clk);
    check("no preempt ready", 32'(bus.cpu_req_ready), 1);
    @(posedge clk); #1;
    bus.cpu_req_valid = 0; bus.isp_lock = 0;
    @(negedge clk);
    check("cpu wr 44", 32'(last_wr), 32'h44);
    check("cpu end owner", 32'(bus.owner), 0);

    // Watchdog: CPU writes 03 then stalls
    @(posedge clk); #1;
    send(0, CMD_WR, 8'h03, 1'b0, "cpu wr 03");
    flush_i = -1; own0_i = -1; evt_n = 0; flush_rdy = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (flush_i < 0 && bus.eng_valid && bus.eng_cmd == CMD_END) begin
        flush_i = i;
        flush_rdy = int'(bus.isp_req_ready) + int'(bus.cpu_req_ready);
      end
      if (bus.timeout_evt) evt_n++;
      if (own0_i < 0 && bus.owner == 0) own0_i = i;
    end
    check("flush cycle", 32'(flush_i), 16);
    check("flush ready", 32'(flush_rdy), 0);
    check("timeout pulses", 32'(evt_n), 1);
    check("flush owner cycle", 32'(own0_i), 17);
    check("cpu wr 03", 32'(last_wr), 32'h03);

    // Raise-CS held off by outstanding read
    @(posedge clk); #1;
    send_rd(1, 8'hA5, "isp rd a5");
    bus.isp_req_valid = 1; bus.isp_req_cmd = CMD_END; bus.isp_req_quad = 0;
    pre_isp = n_isp_rsp; stall = 0; bad = 0; seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.isp_req_ready) begin
        seen = 1;
        break;
      end
      stall++;
      if (bus.eng_valid) bad++;
    end
    @(posedge clk); #1;
    bus.isp_req_valid = 0;
    check("end held accepted", 32'(seen), 1);
    check("end stall cycles", 32'(stall), 3);
    check("eng idle while pend", 32'(bad), 0);
    check("rsp before release", 32'(n_isp_rsp - pre_isp), 1);
    @(negedge clk);
    check("pend release owner", 32'(bus.owner), 0);

    // Unsolicited engine response in IDLE
    @(posedge clk); #1;
    pre_isp = n_isp_rsp; pre_cpu = n_cpu_rsp;
    unsol_pend = 1;
    repeat (4) @(negedge clk);
    check("unsol isp rsp", 32'(n_isp_rsp), 32'(pre_isp));
    check("unsol cpu rsp", 32'(n_cpu_rsp), 32'(pre_cpu));

    // Reset in the middle of a CPU read
    @(posedge clk); #1;
    eng_q.push_back(8'hC3);
    send(0, CMD_RD, 8'h00, 1'b0, "cpu rd mid");
    rst = 1;
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    check("midrst owner", 32'(bus.owner), 0);
    check("midrst eng_valid", 32'(bus.eng_valid), 0);
    pre_isp = n_isp_rsp; pre_cpu = n_cpu_rsp;
    repeat (6) @(negedge clk);
    check("midrst cpu rsp", 32'(n_cpu_rsp), 32'(pre_cpu));
    check("midrst isp rsp", 32'(n_isp_rsp), 32'(pre_isp));

    check("isp exp drained", 32'(exp_isp_q.size()), 0);
    check("cpu exp drained", 32'(exp_cpu_q.size()), 0);
    check("eng bytes drained", 32'(eng_q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
